// File: rtl/alu_deserializer.sv
// Serial receive front end: decodes 11-bit packets into A/B operands and an opcode,
// validates frame length, CRC4 and opcode, and reports one result per cmd packet.
module alu_deserializer #(
  parameter int unsigned DATA_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [2:0]  op_o,
  output logic        valid_o,
  output logic [2:0]  err_o,
  output logic        err_valid_o
);

  localparam int unsigned CntW = $clog2(DATA_BYTES + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(DATA_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StType,
    StPayload,
    StStop,
    StCheck
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      payload_q;
  logic            is_cmd_q;
  logic [63:0]     data_q;
  logic [CntW-1:0] byte_cnt_q;
  logic            ovf_q;

  logic [2:0] cmd_op;
  logic [3:0] cmd_crc;
  logic [3:0] crc_calc;
  logic       op_legal;
  logic       count_ok;

  // x^4 + x + 1, zero seed, MSB first, no final XOR
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign cmd_op   = payload_q[6:4];
  assign cmd_crc  = payload_q[3:0];
  assign crc_calc = crc4({data_q, 1'b1, cmd_op});
  assign op_legal = (cmd_op == 3'b000) || (cmd_op == 3'b001) ||
                    (cmd_op == 3'b100) || (cmd_op == 3'b101);
  assign count_ok = (byte_cnt_q == FullCnt) && !ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (!sin) state_d = StType;
      StType:    state_d = StPayload;
      StPayload: if (bit_cnt_q == 3'd7) state_d = StStop;
      StStop:    state_d = (sin && is_cmd_q) ? StCheck : StIdle;
      // A start bit may follow the cmd stop bit with no idle gap
      StCheck:   state_d = sin ? StIdle : StType;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      payload_q   <= '0;
      is_cmd_q    <= 1'b0;
      data_q      <= '0;
      byte_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      a_o         <= '0;
      b_o         <= '0;
      op_o        <= '0;
      valid_o     <= 1'b0;
      err_o       <= '0;
      err_valid_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      err_valid_o <= 1'b0;
      case (state_q)
        StType: begin
          is_cmd_q  <= sin;
          bit_cnt_q <= '0;
        end
        StPayload: begin
          payload_q <= {payload_q[6:0], sin};
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
        StStop: begin
          if (!sin) begin
            err_o       <= 3'b100;
            err_valid_o <= 1'b1;
            byte_cnt_q  <= '0;
            ovf_q       <= 1'b0;
          end else if (!is_cmd_q) begin
            data_q <= {data_q[55:0], payload_q};
            if (byte_cnt_q == FullCnt) begin
              ovf_q <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        StCheck: begin
          byte_cnt_q <= '0;
          ovf_q      <= 1'b0;
          if (!count_ok) begin
            err_o       <= 3'b100;
            err_valid_o <= 1'b1;
          end else if (crc_calc != cmd_crc) begin
            err_o       <= 3'b010;
            err_valid_o <= 1'b1;
          end else if (!op_legal) begin
            err_o       <= 3'b001;
            err_valid_o <= 1'b1;
          end else begin
            b_o     <= data_q[63:32];
            a_o     <= data_q[31:0];
            op_o    <= cmd_op;
            valid_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_deserializer.sv
// Self-checking bench for alu_deserializer: directed frames from the test plan plus
// randomized frames judged by a frame-level reference model.
module tb_alu_deserializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic [31:0] a_o, b_o;
  logic [2:0]  op_o, err_o;
  logic        valid_o, err_valid_o;

  alu_deserializer #(.DATA_BYTES(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .a_o         (a_o),
    .b_o         (b_o),
    .op_o        (op_o),
    .valid_o     (valid_o),
    .err_o       (err_o),
    .err_valid_o (err_valid_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int cap_vcyc = 0;
  int cap_ecyc = 0;
  logic [31:0] cap_a = '0, cap_b = '0;
  logic [2:0]  cap_op = '0, cap_err = '0;
  logic [31:0] exp_a = '0, exp_b = '0;
  logic [2:0]  exp_op = '0;

  // CRC as the remainder of polynomial long division of msg * x^4 by x^4+x+1
  function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [71:0] r;
    r = {b, a, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  // 3'b000 means the frame is accepted
  function automatic logic [2:0] ref_outcome(input int nbytes, input logic crc_ok,
                                             input logic [2:0] op);
    if (nbytes != 8) return 3'b100;
    if (!crc_ok) return 3'b010;
    if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) return 3'b001;
    return 3'b000;
  endfunction

  // Every driven bit also samples the outputs, so no pulse goes unseen
  task automatic send_bit(input logic b);
    @(negedge clk);
    cyc++;
    if (valid_o) begin
      n_valid++;
      cap_a = a_o;
      cap_b = b_o;
      cap_op = op_o;
      cap_vcyc = cyc;
    end
    if (err_valid_o) begin
      n_err++;
      cap_err = err_o;
      cap_ecyc = cyc;
    end
    if (valid_o && err_valid_o) n_both++;
    sin = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_packet(input logic is_cmd, input logic [7:0] payload, input logic stop);
    send_bit(1'b0);
    send_bit(is_cmd);
    for (int i = 7; i >= 0; i--) send_bit(payload[i]);
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [3:0] crc, input int nbytes, output int start);
    logic [63:0] d;
    logic [7:0]  by;
    d = {b, a};
    start = cyc + 1;
    for (int i = 0; i < nbytes; i++) begin
      by = (i < 8) ? d[63 - 8*i -: 8] : 8'($urandom);
      send_packet(1'b0, by, 1'b1);
    end
    send_packet(1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic test_reset();
    int v0, e0;
    repeat (3) @(negedge clk);
    tests++;
    if ({a_o, b_o, op_o, err_o, valid_o, err_valid_o} !== '0) begin
      fails++;
      $display("FAIL reset_values: got a=%h b=%h op=%b err=%b v=%b ev=%b, want all zero",
               a_o, b_o, op_o, err_o, valid_o, err_valid_o);
    end
    rst_n = 1'b1;
    v0 = n_valid;
    e0 = n_err;
    idle(40);
    tests++;
    if (n_valid != v0 || n_err != e0) begin
      fails++;
      $display("FAIL idle_high: got %0d valid %0d err pulses, want 0 0", n_valid - v0,
               n_err - e0);
    end
  endtask

  task automatic test_basic();
    int v0, e0, st;
    v0 = n_valid;
    e0 = n_err;
    send_frame(32'h0, 32'h0, 3'b000, 4'hB, 8, st);
    idle(3);
    tests++;
    if (n_valid != v0 + 1 || n_err != e0) begin
      fails++;
      $display("FAIL and_pulses: got %0d valid %0d err, want 1 0", n_valid - v0, n_err - e0);
    end
    tests++;
    if (cap_vcyc != st + 100) begin
      fails++;
      $display("FAIL and_latency: got cycle %0d, want %0d", cap_vcyc - st, 100);
    end
    tests++;
    if ({cap_a, cap_b, cap_op} !== {32'h0, 32'h0, 3'b000}) begin
      fails++;
      $display("FAIL and_values: got a=%h b=%h op=%b, want 0 0 000", cap_a, cap_b, cap_op);
    end
    tests++;
    if (valid_o !== 1'b0) begin
      fails++;
      $display("FAIL pulse_width: got valid_o=%b after pulse, want 0", valid_o);
    end
    exp_a = '0;
    exp_b = '0;
    exp_op = 3'b000;

    v0 = n_valid;
    e0 = n_err;
    send_frame(32'h0, 32'h0, 3'b001, 4'h9, 8, st);
    idle(3);
    tests++;
    if (n_err != e0 + 1 || n_valid != v0 || cap_err !== 3'b010) begin
      fails++;
      $display("FAIL bad_crc: got %0d err %0d valid err_o=%b, want 1 0 010", n_err - e0,
               n_valid - v0, cap_err);
    end
    tests++;
    if (cap_ecyc != st + 100 || op_o !== exp_op) begin
      fails++;
      $display("FAIL bad_crc_hold: got cycle %0d op=%b, want 100 %b", cap_ecyc - st, op_o,
               exp_op);
    end

    v0 = n_valid;
    send_frame(32'h0, 32'h0, 3'b001, 4'h8, 8, st);
    idle(3);
    tests++;
    if (n_valid != v0 + 1 || cap_op !== 3'b001) begin
      fails++;
      $display("FAIL or_frame: got %0d valid op=%b, want 1 001", n_valid - v0, cap_op);
    end
    exp_op = 3'b001;
  endtask

  task automatic test_short_frame();
    int v0, e0, st;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    v0 = n_valid;
    e0 = n_err;
    send_frame(a, b, 3'b100, ref_crc(a, b, 3'b100), 7, st);
    idle(3);
    tests++;
    if (n_err != e0 + 1 || n_valid != v0 || cap_err !== 3'b100) begin
      fails++;
      $display("FAIL short_frame: got %0d err %0d valid err_o=%b, want 1 0 100", n_err - e0,
               n_valid - v0, cap_err);
    end
    tests++;
    if ({a_o, b_o, op_o} !== {exp_a, exp_b, exp_op}) begin
      fails++;
      $display("FAIL short_hold: got a=%h b=%h op=%b, want %h %h %b", a_o, b_o, op_o, exp_a,
               exp_b, exp_op);
    end

    v0 = n_valid;
    send_frame(a, b, 3'b100, ref_crc(a, b, 3'b100), 8, st);
    idle(3);
    tests++;
    if (n_valid != v0 + 1 || {cap_a, cap_b, cap_op} !== {a, b, 3'b100}) begin
      fails++;
      $display("FAIL after_short: got %0d valid a=%h b=%h op=%b, want 1 %h %h 100",
               n_valid - v0, cap_a, cap_b, cap_op, a, b);
    end
    exp_a = a;
    exp_b = b;
    exp_op = 3'b100;

    e0 = n_err;
    send_frame(b, a, 3'b000, ref_crc(b, a, 3'b000), 9, st);
    idle(3);
    tests++;
    if (n_err != e0 + 1 || cap_err !== 3'b100) begin
      fails++;
      $display("FAIL overflow: got %0d err err_o=%b, want 1 100", n_err - e0, cap_err);
    end
  endtask

  task automatic test_bad_opcode();
    int v0, e0, st;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    v0 = n_valid;
    e0 = n_err;
    send_frame(a, b, 3'b111, ref_crc(a, b, 3'b111), 8, st);
    idle(3);
    tests++;
    if (n_err != e0 + 1 || n_valid != v0 || cap_err !== 3'b001) begin
      fails++;
      $display("FAIL bad_opcode: got %0d err %0d valid err_o=%b, want 1 0 001", n_err - e0,
               n_valid - v0, cap_err);
    end
  endtask

  task automatic test_reset_midframe();
    int v0, e0, st;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    v0 = n_valid;
    e0 = n_err;
    for (int i = 0; i < 4; i++) send_packet(1'b0, 8'($urandom), 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    tests++;
    if ({a_o, b_o, op_o, err_o, valid_o, err_valid_o} !== '0) begin
      fails++;
      $display("FAIL midframe_reset: got a=%h b=%h op=%b err=%b, want all zero", a_o, b_o,
               op_o, err_o);
    end
    rst_n = 1'b1;
    idle(20);
    tests++;
    if (n_valid != v0 || n_err != e0) begin
      fails++;
      $display("FAIL aborted_frame: got %0d valid %0d err, want 0 0", n_valid - v0, n_err - e0);
    end
    exp_a = '0;
    exp_b = '0;
    exp_op = '0;
    v0 = n_valid;
    send_frame(a, b, 3'b101, ref_crc(a, b, 3'b101), 8, st);
    idle(3);
    tests++;
    if (n_valid != v0 + 1 || {cap_a, cap_b, cap_op} !== {a, b, 3'b101}) begin
      fails++;
      $display("FAIL sub_after_reset: got %0d valid a=%h b=%h op=%b, want 1 %h %h 101",
               n_valid - v0, cap_a, cap_b, cap_op, a, b);
    end
    exp_a = a;
    exp_b = b;
    exp_op = 3'b101;
  endtask

  task automatic test_framing();
    int v0, e0, st0, st;
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    v0 = n_valid;
    e0 = n_err;
    st0 = cyc + 1;
    send_packet(1'b0, 8'($urandom), 1'b0);
    send_frame(a, b, 3'b001, ref_crc(a, b, 3'b001), 8, st);
    idle(3);
    tests++;
    if (n_err != e0 + 1 || cap_err !== 3'b100 || cap_ecyc != st0 + 11) begin
      fails++;
      $display("FAIL framing_err: got %0d err err_o=%b at %0d, want 1 100 at 11", n_err - e0,
               cap_err, cap_ecyc - st0);
    end
    tests++;
    if (n_valid != v0 + 1 || {cap_a, cap_b, cap_op} !== {a, b, 3'b001}) begin
      fails++;
      $display("FAIL after_framing: got %0d valid a=%h b=%h op=%b, want 1 %h %h 001",
               n_valid - v0, cap_a, cap_b, cap_op, a, b);
    end
    exp_a = a;
    exp_b = b;
    exp_op = 3'b001;
  endtask

  task automatic test_back_to_back();
    int v0, st1, st2;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom;
    b1 = $urandom;
    a2 = $urandom;
    b2 = $urandom;
    v0 = n_valid;
    send_frame(a1, b1, 3'b000, ref_crc(a1, b1, 3'b000), 8, st1);
    send_frame(a2, b2, 3'b101, ref_crc(a2, b2, 3'b101), 8, st2);
    idle(3);
    tests++;
    if (n_valid != v0 + 2 || cap_vcyc != st2 + 100) begin
      fails++;
      $display("FAIL back_to_back: got %0d valid last at %0d, want 2 at 100", n_valid - v0,
               cap_vcyc - st2);
    end
    tests++;
    if ({cap_a, cap_b, cap_op} !== {a2, b2, 3'b101}) begin
      fails++;
      $display("FAIL b2b_values: got a=%h b=%h op=%b, want %h %h 101", cap_a, cap_b, cap_op,
               a2, b2);
    end
    exp_a = a2;
    exp_b = b2;
    exp_op = 3'b101;
  endtask

  task automatic test_random();
    int v0, e0, st, nbytes, pick;
    logic [31:0] a, b;
    logic [2:0]  op, exp_e;
    logic [3:0]  crc;
    logic        crc_ok;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      b = $urandom;
      op = 3'($urandom);
      crc_ok = ($urandom_range(0, 3) != 0);
      crc = ref_crc(a, b, op);
      if (!crc_ok) crc = crc ^ 4'($urandom_range(1, 15));
      pick = $urandom_range(0, 4);
      nbytes = (pick == 0) ? 7 : (pick == 4) ? 9 : 8;
      exp_e = ref_outcome(nbytes, crc_ok, op);
      v0 = n_valid;
      e0 = n_err;
      send_frame(a, b, op, crc, nbytes, st);
      idle(2);
      if (exp_e == 3'b000) begin
        tests++;
        if (n_valid != v0 + 1 || n_err != e0 ||
            {cap_a, cap_b, cap_op} !== {a, b, op}) begin
          fails++;
          $display("FAIL rand_good[%0d]: got %0d/%0d a=%h b=%h op=%b, want 1/0 %h %h %b", n,
                   n_valid - v0, n_err - e0, cap_a, cap_b, cap_op, a, b, op);
        end
        exp_a = a;
        exp_b = b;
        exp_op = op;
      end else begin
        tests++;
        if (n_err != e0 + 1 || n_valid != v0 || cap_err !== exp_e ||
            {a_o, b_o, op_o} !== {exp_a, exp_b, exp_op}) begin
          fails++;
          $display("FAIL rand_err[%0d]: got %0d/%0d err_o=%b op=%b, want 0/1 %b %b", n,
                   n_valid - v0, n_err - e0, cap_err, op_o, exp_e, exp_op);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_frame();
    test_bad_opcode();
    test_reset_midframe();
    test_framing();
    test_back_to_back();
    test_random();
    tests++;
    if (n_both != 0) begin
      fails++;
      $display("FAIL exclusive_pulses: got %0d cycles with both pulses, want 0", n_both);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
